// File: rtl/uart_rx_framer.sv
// uart_rx_framer: 8N1-style serial receiver with mid-bit sampling.
// The raw line is double-flopped, each frame is checked for valid start
// and stop bits, and the received byte is handed downstream through a
// single-entry valid/ready holding register. Framing errors and overruns
// are reported as one-cycle pulses.
module uart_rx_framer #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 framing_err,
    output logic                 overrun
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Counter terminal values: half a bit to reach the start-bit centre,
    // a full bit between successive sample points.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_e;

    // Input synchronizer
    logic rx_meta_q;
    logic rx_s_q;

    // FSM
    state_e state_q;
    state_e state_d;

    // Datapath
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     idx_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;

    // Output holding register and pulses
    logic [DATA_BITS-1:0] data_q;
    logic [DATA_BITS-1:0] data_d;
    logic                 valid_q;
    logic                 valid_d;
    logic                 ferr_q;
    logic                 ferr_d;
    logic                 ovr_q;
    logic                 ovr_d;

    // Decoded timing and control strobes
    logic half_tick_c;
    logic full_tick_c;
    logic idx_last_c;
    logic cnt_clr_c;
    logic bit_shift_c;
    logic idx_clr_c;
    logic deliver_c;
    logic stop_bad_c;
    logic accept_c;

    assign half_tick_c = (cnt_q == HALF_LAST);
    assign full_tick_c = (cnt_q == FULL_LAST);
    assign idx_last_c  = (idx_q == IDX_LAST);
    assign accept_c    = valid_q & ready;

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                // A line back high at mid-start is a glitch, not a frame
                if (half_tick_c) begin
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (full_tick_c && idx_last_c) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (full_tick_c) begin
                    state_d = rx_s_q ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                // Hold off until the line recovers so a long low gives one error
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM output decode: datapath strobes derived from state and timing
    always_comb begin
        cnt_clr_c   = 1'b0;
        bit_shift_c = 1'b0;
        idx_clr_c   = 1'b0;
        deliver_c   = 1'b0;
        stop_bad_c  = 1'b0;
        // Counter restarts on every state entry and after each data sample
        if (state_d != state_q) begin
            cnt_clr_c = 1'b1;
        end
        unique case (state_q)
            S_IDLE: begin
                cnt_clr_c = 1'b1;
            end
            S_START: begin
                idx_clr_c = 1'b1;
            end
            S_DATA: begin
                if (full_tick_c) begin
                    cnt_clr_c   = 1'b1;
                    bit_shift_c = 1'b1;
                end
            end
            S_STOP: begin
                if (full_tick_c) begin
                    deliver_c  = rx_s_q;
                    stop_bad_c = ~rx_s_q;
                end
            end
            S_BREAK: begin
                cnt_clr_c = 1'b1;
            end
            default: begin
                cnt_clr_c = 1'b1;
            end
        endcase
    end

    // Datapath next-state: bit-period counter, bit index, shift register
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        if (cnt_clr_c) begin
            cnt_d = '0;
        end
        if (idx_clr_c) begin
            idx_d = '0;
        end else if (bit_shift_c) begin
            idx_d = idx_q + IDX_W'(1);
        end
        // LSB arrives first, so shifting right leaves it at bit 0 at the end
        if (bit_shift_c) begin
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Holding register: same-cycle accept and refill, overrun when full
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = stop_bad_c;
        ovr_d   = 1'b0;
        if (deliver_c) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (accept_c) begin
            valid_d = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign framing_err = ferr_q;
    assign overrun     = ovr_q;

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed testbench for uart_rx_framer at 8 clocks per bit.
module tb_uart_rx_framer;

    localparam int unsigned N = 8;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       framing_err;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    // Event counters maintained on every falling edge
    int         vrise_cnt  = 0;
    int         fe_cnt     = 0;
    int         ov_cnt     = 0;
    int         both_cnt   = 0;
    logic [7:0] last_data  = 8'h00;
    logic       valid_prev = 1'b0;

    uart_rx_framer #(
        .CLKS_PER_BIT(N),
        .DATA_BITS   (8)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .framing_err(framing_err),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    // Track valid rising edges, presented bytes and error pulses
    always @(negedge clock) begin
        if (valid && !valid_prev) begin
            vrise_cnt <= vrise_cnt + 1;
            last_data <= data;
        end
        valid_prev <= valid;
        if (framing_err) fe_cnt <= fe_cnt + 1;
        if (overrun) ov_cnt <= ov_cnt + 1;
        if (framing_err && overrun) both_cnt <= both_cnt + 1;
    end

    // Drive one frame; caller is on a falling edge, returns on a falling edge
    // with the line left at the stop-bit level.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (N) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (N) @(negedge clock);
        end
        rx = stop_bit;
        repeat (N) @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx      = 1'b1;
        ready   = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
        checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", framing_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", overrun); end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (10) @(negedge clock);
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b expected 0", valid); end
    endtask

    task automatic test_frame_55();
        int         v0, f0, o0;
        int         first;
        logic [7:0] got;
        first = 0;
        got   = 8'h00;
        ready = 1'b1;
        @(negedge clock);
        v0 = vrise_cnt; f0 = fe_cnt; o0 = ov_cnt;
        fork
            send_frame(8'h55, 1'b1);
            begin
                for (int i = 1; i <= 120; i++) begin
                    @(negedge clock);
                    if (valid && first == 0) begin
                        first = i;
                        got   = data;
                    end
                end
            end
        join
        #1;
        checks++; if (first !== 79) begin errors++; $display("FAIL f55_latency: got %0d expected 79", first); end
        checks++; if (got !== 8'h55) begin errors++; $display("FAIL f55_data: got %h expected 55", got); end
        checks++; if (vrise_cnt - v0 !== 1) begin errors++; $display("FAIL f55_valid_count: got %0d expected 1", vrise_cnt - v0); end
        checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL f55_ferr: got %0d expected 0", fe_cnt - f0); end
        checks++; if (ov_cnt - o0 !== 0) begin errors++; $display("FAIL f55_ovr: got %0d expected 0", ov_cnt - o0); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL f55_valid_drop: got %b expected 0", valid); end
    endtask

    task automatic test_back_to_back();
        int v0, f0, o0;
        ready = 1'b0;
        @(negedge clock);
        v0 = vrise_cnt; f0 = fe_cnt; o0 = ov_cnt;
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        repeat (4) @(negedge clock);
        #1;
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_held: got %b expected 1", valid); end
        checks++; if (data !== 8'hA3) begin errors++; $display("FAIL b2b_data_held: got %h expected a3", data); end
        checks++; if (ov_cnt - o0 !== 1) begin errors++; $display("FAIL b2b_overrun: got %0d expected 1", ov_cnt - o0); end
        checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL b2b_ferr: got %0d expected 0", fe_cnt - f0); end
        @(negedge clock);
        ready = 1'b1;
        @(negedge clock);
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %b expected 0", valid); end
        repeat (30) @(negedge clock);
        #1;
        checks++; if (vrise_cnt - v0 !== 1) begin errors++; $display("FAIL b2b_presented: got %0d expected 1", vrise_cnt - v0); end
        checks++; if (data !== 8'hA3) begin errors++; $display("FAIL b2b_no_0f: got %h expected a3", data); end
    endtask

    task automatic test_accept_refill();
        int v0, o0;
        ready = 1'b0;
        @(negedge clock);
        v0 = vrise_cnt; o0 = ov_cnt;
        fork
            begin
                send_frame(8'h12, 1'b1);
                send_frame(8'h34, 1'b1);
            end
            begin
                repeat (158) @(negedge clock);
                checks++; if (data !== 8'h12) begin errors++; $display("FAIL ar_first: got %h expected 12", data); end
                ready = 1'b1;
                @(negedge clock);
                ready = 1'b0;
                checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ar_valid_kept: got %b expected 1", valid); end
                checks++; if (data !== 8'h34) begin errors++; $display("FAIL ar_refill: got %h expected 34", data); end
            end
        join
        repeat (4) @(negedge clock);
        #1;
        checks++; if (ov_cnt - o0 !== 0) begin errors++; $display("FAIL ar_overrun: got %0d expected 0", ov_cnt - o0); end
        checks++; if (vrise_cnt - v0 !== 1) begin errors++; $display("FAIL ar_valid_rises: got %0d expected 1", vrise_cnt - v0); end
        ready = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ar_drain: got %b expected 0", valid); end
    endtask

    task automatic test_glitch();
        int v0, f0;
        ready = 1'b1;
        @(negedge clock);
        v0 = vrise_cnt; f0 = fe_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clock);
        rx = 1'b1;
        repeat (40) @(negedge clock);
        #1;
        checks++; if (vrise_cnt - v0 !== 0) begin errors++; $display("FAIL glitch_valid: got %0d expected 0", vrise_cnt - v0); end
        checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_ferr: got %0d expected 0", fe_cnt - f0); end
        @(negedge clock);
        send_frame(8'h5A, 1'b1);
        repeat (10) @(negedge clock);
        #1;
        checks++; if (vrise_cnt - v0 !== 1) begin errors++; $display("FAIL glitch_next_count: got %0d expected 1", vrise_cnt - v0); end
        checks++; if (last_data !== 8'h5A) begin errors++; $display("FAIL glitch_next_data: got %h expected 5a", last_data); end
    endtask

    task automatic test_framing_break();
        int v0, f0, o0;
        ready = 1'b1;
        @(negedge clock);
        v0 = vrise_cnt; f0 = fe_cnt; o0 = ov_cnt;
        send_frame(8'hFF, 1'b0);
        repeat (40) @(negedge clock);
        rx = 1'b1;
        repeat (10) @(negedge clock);
        #1;
        checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL brk_ferr_count: got %0d expected 1", fe_cnt - f0); end
        checks++; if (vrise_cnt - v0 !== 0) begin errors++; $display("FAIL brk_valid: got %0d expected 0", vrise_cnt - v0); end
        checks++; if (ov_cnt - o0 !== 0) begin errors++; $display("FAIL brk_ovr: got %0d expected 0", ov_cnt - o0); end
        @(negedge clock);
        send_frame(8'h3C, 1'b1);
        repeat (10) @(negedge clock);
        #1;
        checks++; if (vrise_cnt - v0 !== 1) begin errors++; $display("FAIL brk_next_count: got %0d expected 1", vrise_cnt - v0); end
        checks++; if (last_data !== 8'h3C) begin errors++; $display("FAIL brk_next_data: got %h expected 3c", last_data); end
        checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL brk_ferr_after: got %0d expected 1", fe_cnt - f0); end
    endtask

    task automatic test_reset_mid();
        int v0;
        ready = 1'b0;
        @(negedge clock);
        send_frame(8'h66, 1'b1);
        repeat (3) @(negedge clock);
        checks++; if (data !== 8'h66) begin errors++; $display("FAIL rst_pre_data: got %h expected 66", data); end
        fork
            send_frame(8'h77, 1'b1);
            begin
                repeat (44) @(negedge clock);
                #2;
                reset_n = 1'b0;
                #1;
                checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", valid); end
                checks++; if (data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", data); end
                checks++; if (framing_err !== 1'b0) begin errors++; $display("FAIL rst_ferr: got %b expected 0", framing_err); end
                checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr: got %b expected 0", overrun); end
            end
        join
        reset_n = 1'b1;
        repeat (20) @(negedge clock);
        ready = 1'b1;
        v0 = vrise_cnt;
        send_frame(8'h81, 1'b1);
        repeat (10) @(negedge clock);
        #1;
        checks++; if (vrise_cnt - v0 !== 1) begin errors++; $display("FAIL rst_next_count: got %0d expected 1", vrise_cnt - v0); end
        checks++; if (last_data !== 8'h81) begin errors++; $display("FAIL rst_next_data: got %h expected 81", last_data); end
    endtask

    initial begin
        rx      = 1'b1;
        ready   = 1'b0;
        reset_n = 1'b0;
        test_reset();
        test_frame_55();
        test_back_to_back();
        test_accept_refill();
        test_glitch();
        test_framing_break();
        test_reset_mid();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL err_exclusive: got %0d expected 0", both_cnt); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
